// File: rtl/axis_pkt_filter_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_filter_pkg
// Shared types and register map for the axis_pkt_filter_drop packet filter.
//   rule_t          one match rule: enable, word index, action, value, mask
//   mode_e          filter mode held in the mode register
//   ADDR_*          register byte addresses
//   pack_rule_ctrl  formats a rule's control word for register readback
// -----------------------------------------------------------------------------
package axis_pkt_filter_pkg;

    // A 4-bit word index can select at most 16 words of the first beat.
    localparam int MAX_WORDS = 16;
    localparam int MAX_RULES = 16;

    localparam logic [15:0] ADDR_MODE      = 16'h1000;
    localparam logic [15:0] ADDR_CLEAR     = 16'h1004;
    localparam logic [15:0] ADDR_PASS_CNT  = 16'h1008;
    localparam logic [15:0] ADDR_DROP_CNT  = 16'h100C;
    localparam logic [15:0] ADDR_RULE_BASE = 16'h1100;
    localparam logic [15:0] ADDR_HIT_BASE  = 16'h1200;

    // Offsets inside one 16-byte rule slot.
    localparam logic [3:0] RULE_OFS_CTRL  = 4'h0;
    localparam logic [3:0] RULE_OFS_VALUE = 4'h4;
    localparam logic [3:0] RULE_OFS_MASK  = 4'h8;

    typedef enum logic [1:0] {
        MODE_PASS_ALL   = 2'd0,
        MODE_DROP_ALL   = 2'd1,
        MODE_RULES_PASS = 2'd2,
        MODE_RULES_DROP = 2'd3
    } mode_e;

    typedef struct packed {
        logic        en;
        logic [3:0]  idx;
        logic        action;   // 1 = drop
        logic [31:0] value;
        logic [31:0] mask;
    } rule_t;

    // Control word layout: {action[8], idx[7:4], en[0]}
    function automatic logic [31:0] pack_rule_ctrl(input rule_t rule);
        return {23'd0, rule.action, rule.idx, 3'd0, rule.en};
    endfunction

endpackage

// File: rtl/axis_pkt_filter_rule_match.sv
// -----------------------------------------------------------------------------
// axis_pkt_filter_rule_match
// Compares one 32-bit word of a beat against a single masked rule.
//   i_rule   rule to evaluate (enable, word index, value, mask)
//   i_tdata  beat data; only meaningful on the first beat of a packet
//   o_hit    1 when the rule is enabled, its index addresses a word that
//            exists in the beat, and the masked word equals the masked value
// -----------------------------------------------------------------------------
module axis_pkt_filter_rule_match
    import axis_pkt_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  rule_t                 i_rule,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    output logic                  o_hit
);

    localparam int NUM_WORDS = DATA_WIDTH / 32;

    logic [31:0] w_words [MAX_WORDS];
    logic [31:0] w_word;
    logic        w_idx_valid;

    // Words past the end of a narrow bus read as zero; the index check below
    // keeps them from ever producing a hit.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_WORDS; gi++) begin : g_word
            if (gi < NUM_WORDS) begin : g_live
                assign w_words[gi] = i_tdata[32*gi +: 32];
            end else begin : g_pad
                assign w_words[gi] = '0;
            end
        end
    endgenerate

    assign w_word      = w_words[i_rule.idx];
    assign w_idx_valid = ({28'd0, i_rule.idx} < 32'(NUM_WORDS));
    assign o_hit       = i_rule.en && w_idx_valid &&
                         (((w_word ^ i_rule.value) & i_rule.mask) == 32'd0);

endmodule

// File: rtl/axis_pkt_filter_drop.sv
// -----------------------------------------------------------------------------
// axis_pkt_filter_drop
// Packet filter on an AXI-Stream path. Each packet is classified on its first
// beat against NUM_RULES masked word rules and is then forwarded or silently
// dropped as a whole. Saturating pass/drop counters are kept.
//
// Ports
//   axis_aclk / axis_rst        clock, asynchronous active-high reset
//   s_axis_t*                   input stream (data, keep, user, last, valid, ready)
//   m_axis_t*                   output stream, one register stage
//   cfg_wr / cfg_rd             register write / read strobes
//   cfg_addr / cfg_wdata        byte address and write data
//   cfg_rdata / cfg_rvalid      read data, valid one cycle after cfg_rd
//
// Optional macro AXIS_PKT_FILTER_RULE_HIT_CNT_EN adds per-rule saturating hit
// counters readable at 0x1200 + 4*r; without it that region reads 0.
// -----------------------------------------------------------------------------
module axis_pkt_filter_drop
    import axis_pkt_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 1,
    parameter int NUM_RULES  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    axis_aclk,
    input  logic                    axis_rst,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,

    input  logic                    cfg_wr,
    input  logic                    cfg_rd,
    input  logic [15:0]             cfg_addr,
    input  logic [31:0]             cfg_wdata,
    output logic [31:0]             cfg_rdata,
    output logic                    cfg_rvalid
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                  w_tready;
    logic                  w_accept;
    logic                  w_sop_accept;
    logic                  w_eop_accept;

    logic                  r_sop;
    logic                  r_drop_q;
    mode_e                 r_mode;

    rule_t                 w_rules [NUM_RULES];
    logic [NUM_RULES-1:0]  w_rule_hit;
    logic [NUM_RULES-1:0]  w_rule_action;
    logic [NUM_RULES-1:0]  w_first_hit;
    logic                  w_hit_any;
    logic                  w_hit_action;
    logic                  w_rules_mode;
    logic                  w_sop_drop;
    logic                  w_beat_drop;

    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic [USER_WIDTH-1:0] r_m_tuser;
    logic                  r_m_tlast;
    logic                  r_m_tvalid;

    logic [CNT_WIDTH-1:0]  r_pass_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic                  w_mode_wr;
    logic                  w_clear;
    logic                  w_rule_region;
    logic [31:0]           w_rd_data;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;

`ifdef AXIS_PKT_FILTER_RULE_HIT_CNT_EN
    logic [CNT_WIDTH-1:0]  w_hit_cnt [NUM_RULES];
`endif

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // Dropped beats use the same ready as forwarded ones, so a drop never
    // bypasses a stalled output beat. Ready is held low while in reset.
    assign w_tready      = !r_m_tvalid || m_axis_tready;
    assign s_axis_tready = w_tready && !axis_rst;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_sop_accept  = w_accept && r_sop;
    assign w_eop_accept  = w_accept && s_axis_tlast;

    // ------------------------------------------------------------------------
    // Config decode
    // ------------------------------------------------------------------------
    assign w_mode_wr     = cfg_wr && (cfg_addr == ADDR_MODE);
    assign w_clear       = cfg_wr && (cfg_addr == ADDR_CLEAR) && cfg_wdata[0];
    assign w_rule_region = (cfg_addr[15:8] == ADDR_RULE_BASE[15:8]);

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_mode <= MODE_PASS_ALL;
        end else if (w_mode_wr) begin
            r_mode <= mode_e'(cfg_wdata[1:0]);
        end
    end

    // ------------------------------------------------------------------------
    // Per-rule registers, comparators and optional hit counters
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RULES; gi++) begin : g_rule
            rule_t r_rule;
            logic  w_rule_wr;

            assign w_rule_wr = cfg_wr && w_rule_region && (cfg_addr[7:4] == 4'(gi));

            always_ff @(posedge axis_aclk or posedge axis_rst) begin
                if (axis_rst) begin
                    r_rule <= '0;
                end else if (w_rule_wr) begin
                    case (cfg_addr[3:0])
                        RULE_OFS_CTRL: begin
                            r_rule.en     <= cfg_wdata[0];
                            r_rule.idx    <= cfg_wdata[7:4];
                            r_rule.action <= cfg_wdata[8];
                        end
                        RULE_OFS_VALUE: r_rule.value <= cfg_wdata;
                        RULE_OFS_MASK:  r_rule.mask  <= cfg_wdata;
                        default: ;
                    endcase
                end
            end

            assign w_rules[gi]       = r_rule;
            assign w_rule_action[gi] = r_rule.action;

            axis_pkt_filter_rule_match #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rule_match (
                .i_rule  (r_rule),
                .i_tdata (s_axis_tdata),
                .o_hit   (w_rule_hit[gi])
            );

`ifdef AXIS_PKT_FILTER_RULE_HIT_CNT_EN
            logic [CNT_WIDTH-1:0] r_hit_cnt;

            // Only counts when the rules actually decided the packet.
            always_ff @(posedge axis_aclk or posedge axis_rst) begin
                if (axis_rst) begin
                    r_hit_cnt <= '0;
                end else if (w_clear) begin
                    r_hit_cnt <= '0;
                end else if (w_sop_accept && w_rules_mode && w_first_hit[gi] &&
                             (r_hit_cnt != CNT_MAX)) begin
                    r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
                end
            end

            assign w_hit_cnt[gi] = r_hit_cnt;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Priority and decision
    // ------------------------------------------------------------------------
    // x & -x isolates the lowest set bit: the lowest-index matching rule wins.
    assign w_first_hit  = w_rule_hit & (-w_rule_hit);
    assign w_hit_any    = |w_rule_hit;
    assign w_hit_action = |(w_first_hit & w_rule_action);
    assign w_rules_mode = (r_mode == MODE_RULES_PASS) || (r_mode == MODE_RULES_DROP);

    always_comb begin
        w_sop_drop = 1'b0;
        case (r_mode)
            MODE_PASS_ALL:   w_sop_drop = 1'b0;
            MODE_DROP_ALL:   w_sop_drop = 1'b1;
            MODE_RULES_PASS: w_sop_drop = w_hit_any && w_hit_action;
            MODE_RULES_DROP: w_sop_drop = !w_hit_any || w_hit_action;
            default:         w_sop_drop = 1'b0;
        endcase
    end

    // The first beat uses the live decision; later beats reuse the latched
    // one, so config changes during a packet only affect the next packet.
    assign w_beat_drop = r_sop ? w_sop_drop : r_drop_q;

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_sop    <= 1'b1;
            r_drop_q <= 1'b0;
        end else if (w_accept) begin
            r_sop    <= s_axis_tlast;
            r_drop_q <= w_beat_drop;
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_tready) begin
            r_m_tvalid <= w_accept && !w_beat_drop;
            if (w_accept && !w_beat_drop) begin
                r_m_tdata <= s_axis_tdata;
                r_m_tkeep <= s_axis_tkeep;
                r_m_tuser <= s_axis_tuser;
                r_m_tlast <= s_axis_tlast;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;

    // ------------------------------------------------------------------------
    // Packet counters: a packet is counted on its accepted last beat.
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_clear) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_eop_accept) begin
            if (w_beat_drop) begin
                if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end else begin
                if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register readback
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        if (cfg_addr == ADDR_MODE) begin
            w_rd_data = {30'd0, r_mode};
        end else if (cfg_addr == ADDR_PASS_CNT) begin
            w_rd_data = 32'(r_pass_cnt);
        end else if (cfg_addr == ADDR_DROP_CNT) begin
            w_rd_data = 32'(r_drop_cnt);
        end else if (w_rule_region) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (cfg_addr[7:4] == 4'(r)) begin
                    case (cfg_addr[3:0])
                        RULE_OFS_CTRL:  w_rd_data = pack_rule_ctrl(w_rules[r]);
                        RULE_OFS_VALUE: w_rd_data = w_rules[r].value;
                        RULE_OFS_MASK:  w_rd_data = w_rules[r].mask;
                        default:        w_rd_data = '0;
                    endcase
                end
            end
        end
`ifdef AXIS_PKT_FILTER_RULE_HIT_CNT_EN
        else if ((cfg_addr[15:8] == ADDR_HIT_BASE[15:8]) && (cfg_addr[1:0] == 2'b00)) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (cfg_addr[7:2] == 6'(r)) begin
                    w_rd_data = 32'(w_hit_cnt[r]);
                end
            end
        end
`endif
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= cfg_rd;
            r_rdata  <= cfg_rd ? w_rd_data : 32'd0;
        end
    end

    assign cfg_rvalid = r_rvalid;
    assign cfg_rdata  = r_rdata;

endmodule

// File: tb/tb_axis_pkt_filter_drop.sv
`timescale 1ns/1ps
module tb_axis_pkt_filter_drop;
    import axis_pkt_filter_pkg::*;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 1;
    localparam int NR = 4;
    localparam int CW = 3;   // narrow counters so saturation is reachable

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          cfg_wr = 1'b0;
    logic          cfg_rd = 1'b0;
    logic [15:0]   cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          cfg_rvalid;

    always #5 clk = ~clk;

    axis_pkt_filter_drop #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .NUM_RULES  (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_aclk     (clk),
        .axis_rst      (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .cfg_wr        (cfg_wr),
        .cfg_rd        (cfg_rd),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .cfg_rvalid    (cfg_rvalid)
    );

    int vectors = 0;
    int miscompares = 0;

    // Output capture; inputs only change just after posedge, so the
    // negedge view equals what the next posedge will transfer.
    logic [DW-1:0] cap_data [$];
    logic [KW-1:0] cap_keep [$];
    logic [UW-1:0] cap_user [$];
    logic          cap_last [$];
    int            tvalid_seen = 0;

    always @(negedge clk) begin
        if (m_tvalid === 1'b1) tvalid_seen++;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            cap_data.push_back(m_tdata);
            cap_keep.push_back(m_tkeep);
            cap_user.push_back(m_tuser);
            cap_last.push_back(m_tlast);
            $display("beat out: last=%0b user=%0h keep=%h word3=%h", m_tlast, m_tuser, m_tkeep, m_tdata[96 +: 32]);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    function automatic logic [DW-1:0] pkt_beat(input logic [31:0] w3_first, input logic [31:0] w3_rest,
                                               input int pkt, input int beat);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = {8'(8'hC0 + pkt), 8'(beat), 8'(i), 8'h5A};
        d[96 +: 32] = (beat == 0) ? w3_first : w3_rest;
        return d;
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int beat, input int nbeats);
        logic [KW-1:0] k;
        k = '1;
        if (beat == nbeats - 1) k = {{(KW-16){1'b0}}, 16'hFFFF};
        return k;
    endfunction

    task automatic send_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                             input logic [UW-1:0] user, input logic last, input bit toggle);
        bit accepted;
        int guard;
        accepted = 1'b0;
        guard = 0;
        s_tdata = data; s_tkeep = keep; s_tuser = user; s_tlast = last; s_tvalid = 1'b1;
        while (!accepted && guard < 64) begin
            if (toggle) m_tready = ~m_tready;
            @(negedge clk);
            accepted = (s_tready === 1'b1);
            @(posedge clk); #1;
            guard++;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (!accepted) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: tready got 0 for 64 cycles want 1");
        end
    endtask

    task automatic send_pkt(input logic [31:0] w3_first, input logic [31:0] w3_rest, input int pkt,
                            input int nbeats, input bit toggle);
        for (int b = 0; b < nbeats; b++)
            send_beat(pkt_beat(w3_first, w3_rest, pkt, b), beat_keep(b, nbeats), UW'(b & 1), b == nbeats - 1, toggle);
    endtask

    task automatic drain();
        m_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] addr, input logic [31:0] data);
        cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        $display("cfg write [%h] = %h", addr, data);
    endtask

    task automatic cfg_read(input logic [15:0] addr, output logic [31:0] data, output logic valid);
        cfg_rd = 1'b1; cfg_addr = addr;
        @(posedge clk); #1;
        cfg_rd = 1'b0;
        data = cfg_rdata; valid = cfg_rvalid;
        $display("cfg read  [%h] -> %h (rvalid=%0b)", addr, data, valid);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [31:0] rd; logic rv;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
        vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
        vectors++; if (cfg_rvalid !== 1'b0 || cfg_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_cfg: got rvalid=%b rdata=%h want 0/0", cfg_rvalid, cfg_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b want 1", s_tready); end
        cfg_read(ADDR_MODE, rd, rv);
        vectors++; if (rv !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL reset_mode: got rvalid=%b data=%h want 1/0", rv, rd); end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_pass_cnt: got %h want 0", rd); end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %h want 0", rd); end
        cfg_read(ADDR_RULE_BASE, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_rule0_ctrl: got %h want 0", rd); end
    endtask

    task automatic test_drop_all();
        logic [31:0] rd; logic rv; int tv0;
        tv0 = tvalid_seen;
        cfg_write(ADDR_MODE, 32'd1);
        send_beat({{(DW-32){1'b0}}, 32'h0000_0900}, '1, '0, 1'b1, 1'b0);
        drain();
        vectors++; if (tvalid_seen != tv0) begin miscompares++; $display("FAIL drop_all_tvalid: got %0d valid cycles want 0", tvalid_seen - tv0); end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL drop_all_drop_cnt: got %0d want 1", rd); end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL drop_all_pass_cnt: got %0d want 0", rd); end
        cfg_read(ADDR_MODE, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL drop_all_mode_rb: got %0d want 1", rd); end
    endtask

    task automatic test_pass_backpressure();
        logic [31:0] rd; logic rv; int base;
        cfg_write(ADDR_MODE, 32'd0);
        cfg_write(ADDR_CLEAR, 32'd1);
        base = cap_data.size();
        send_pkt(32'h1111_2222, 32'h3333_4444, 2, 3, 1'b1);
        drain();
        vectors++; if (cap_data.size() != base + 3) begin miscompares++; $display("FAIL bp_beat_count: got %0d want 3", cap_data.size() - base); end
        if (cap_data.size() == base + 3) begin
            for (int b = 0; b < 3; b++) begin
                vectors++;
                if (cap_data[base+b] !== pkt_beat(32'h1111_2222, 32'h3333_4444, 2, b) || cap_keep[base+b] !== beat_keep(b, 3) ||
                    cap_user[base+b] !== UW'(b & 1) || cap_last[base+b] !== (b == 2)) begin
                    miscompares++;
                    $display("FAIL bp_beat%0d: got keep=%h last=%b user=%h word3=%h want keep=%h last=%b user=%0d",
                             b, cap_keep[base+b], cap_last[base+b], cap_user[base+b], cap_data[base+b][96 +: 32], beat_keep(b, 3), b == 2, b & 1);
                end
            end
        end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL bp_pass_cnt: got %0d want 1", rd); end
    endtask

    task automatic test_rule_match();
        logic [31:0] rd; logic rv; int base;
        cfg_write(ADDR_RULE_BASE + 16'h0, 32'h0000_0131);
        cfg_write(ADDR_RULE_BASE + 16'h4, 32'h0000_0800);
        cfg_write(ADDR_RULE_BASE + 16'h8, 32'h0000_FFFF);
        cfg_write(ADDR_MODE, 32'd2);
        cfg_write(ADDR_CLEAR, 32'd1);
        base = cap_data.size();
        // Second beat of each packet carries the other word3 to show the
        // decision is taken from the first beat only.
        send_pkt(32'h1A00_0800, 32'h1A00_86DD, 3, 2, 1'b0);
        send_pkt(32'h1A00_86DD, 32'h1A00_0800, 4, 2, 1'b0);
        drain();
        vectors++; if (cap_data.size() != base + 2) begin miscompares++; $display("FAIL rule_beat_count: got %0d want 2", cap_data.size() - base); end
        if (cap_data.size() == base + 2) begin
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (cap_data[base+b] !== pkt_beat(32'h1A00_86DD, 32'h1A00_0800, 4, b) || cap_last[base+b] !== (b == 1)) begin
                    miscompares++;
                    $display("FAIL rule_beat%0d: got word3=%h tag=%h last=%b want word3=%h tag=c4",
                             b, cap_data[base+b][96 +: 32], cap_data[base+b][31:24], cap_last[base+b], (b == 0) ? 32'h1A00_86DD : 32'h1A00_0800);
                end
            end
        end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL rule_drop_cnt: got %0d want 1", rd); end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL rule_pass_cnt: got %0d want 1", rd); end
        cfg_read(ADDR_RULE_BASE, rd, rv);
        vectors++; if (rd !== 32'h0000_0131) begin miscompares++; $display("FAIL rule_ctrl_rb: got %h want 00000131", rd); end
        cfg_read(ADDR_RULE_BASE + 16'h8, rd, rv);
        vectors++; if (rd !== 32'h0000_FFFF) begin miscompares++; $display("FAIL rule_mask_rb: got %h want 0000ffff", rd); end
    endtask

    task automatic test_priority();
        logic [31:0] rd; logic rv; int base;
        cfg_write(ADDR_RULE_BASE + 16'h00, 32'h0000_0031);   // rule0: idx3, pass
        cfg_write(ADDR_RULE_BASE + 16'h10, 32'h0000_0131);   // rule1: idx3, drop
        cfg_write(ADDR_RULE_BASE + 16'h14, 32'h1A00_0000);
        cfg_write(ADDR_RULE_BASE + 16'h18, 32'hFF00_0000);
        cfg_write(ADDR_MODE, 32'd2);
        cfg_write(ADDR_CLEAR, 32'd1);
        base = cap_data.size();
        send_pkt(32'h1A00_0800, 32'h0, 5, 1, 1'b0);
        drain();
        vectors++; if (cap_data.size() != base + 1) begin miscompares++; $display("FAIL prio_beat_count: got %0d want 1", cap_data.size() - base); end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL prio_pass_cnt: got %0d want 1", rd); end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL prio_drop_cnt: got %0d want 0", rd); end
`ifdef AXIS_PKT_FILTER_RULE_HIT_CNT_EN
        cfg_read(ADDR_HIT_BASE, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL prio_hit0: got %0d want 1", rd); end
        cfg_read(ADDR_HIT_BASE + 16'h4, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL prio_hit1: got %0d want 0", rd); end
`else
        cfg_read(ADDR_HIT_BASE, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL prio_hit_region: got %h want 0", rd); end
`endif
        // Mode 3: rule0 disabled, rule1 drops a match, a miss defaults to drop.
        cfg_write(ADDR_RULE_BASE + 16'h00, 32'h0000_0030);
        cfg_write(ADDR_MODE, 32'd3);
        base = cap_data.size();
        send_pkt(32'h1A00_0800, 32'h0, 6, 1, 1'b0);
        send_pkt(32'h2B00_0000, 32'h0, 7, 2, 1'b0);
        drain();
        vectors++; if (cap_data.size() != base) begin miscompares++; $display("FAIL mode3_beat_count: got %0d want 0", cap_data.size() - base); end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd2) begin miscompares++; $display("FAIL mode3_drop_cnt: got %0d want 2", rd); end
    endtask

    task automatic test_mode_change_mid_packet();
        logic [31:0] rd; logic rv; int base;
        cfg_write(ADDR_MODE, 32'd0);
        cfg_write(ADDR_CLEAR, 32'd1);
        base = cap_data.size();
        send_beat(pkt_beat(32'h5, 32'h6, 8, 0), beat_keep(0, 3), UW'(0), 1'b0, 1'b0);
        cfg_write(ADDR_MODE, 32'd1);
        send_beat(pkt_beat(32'h5, 32'h6, 8, 1), beat_keep(1, 3), UW'(1), 1'b0, 1'b0);
        send_beat(pkt_beat(32'h5, 32'h6, 8, 2), beat_keep(2, 3), UW'(0), 1'b1, 1'b0);
        send_pkt(32'h7, 32'h0, 9, 1, 1'b0);
        drain();
        vectors++; if (cap_data.size() != base + 3) begin miscompares++; $display("FAIL midmode_beat_count: got %0d want 3", cap_data.size() - base); end
        if (cap_data.size() == base + 3) begin
            for (int b = 0; b < 3; b++) begin
                vectors++;
                if (cap_data[base+b] !== pkt_beat(32'h5, 32'h6, 8, b) || cap_last[base+b] !== (b == 2)) begin
                    miscompares++;
                    $display("FAIL midmode_beat%0d: got tag=%h beat=%h last=%b want tag=c8 beat=%0d", b, cap_data[base+b][31:24], cap_data[base+b][23:16], cap_last[base+b], b);
                end
            end
        end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL midmode_pass_cnt: got %0d want 1", rd); end
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL midmode_drop_cnt: got %0d want 1", rd); end
    endtask

    task automatic test_counters();
        logic [31:0] rd; logic rv;
        cfg_write(ADDR_MODE, 32'd1);
        cfg_write(ADDR_CLEAR, 32'd1);
        for (int p = 0; p < 7; p++) send_pkt(32'h0, 32'h0, 10, 1, 1'b0);
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd7) begin miscompares++; $display("FAIL cnt_full: got %0d want 7", rd); end
        send_pkt(32'h0, 32'h0, 11, 1, 1'b0);
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd7) begin miscompares++; $display("FAIL cnt_saturate: got %0d want 7", rd); end
        // Clear in the same cycle as a counted last beat.
        cfg_wr = 1'b1; cfg_addr = ADDR_CLEAR; cfg_wdata = 32'd1;
        s_tdata = pkt_beat(32'h0, 32'h0, 12, 0); s_tkeep = '1; s_tuser = '0; s_tlast = 1'b1; s_tvalid = 1'b1;
        vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL cnt_clear_ready: got %b want 1", s_tready); end
        @(posedge clk); #1;
        cfg_wr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL cnt_clear_wins: got %0d want 0", rd); end
        send_pkt(32'h0, 32'h0, 13, 1, 1'b0);
        cfg_write(ADDR_CLEAR, 32'd2);   // bit0 clear: must not clear
        cfg_read(ADDR_DROP_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL cnt_after_clear: got %0d want 1", rd); end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] rd; logic rv; int base;
        cfg_write(ADDR_MODE, 32'd0);
        m_tready = 1'b0;
        send_beat(pkt_beat(32'h9, 32'hA, 14, 0), beat_keep(0, 3), UW'(0), 1'b0, 1'b0);
        vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_stalled: got %b want 1", m_tvalid); end
        rst = 1'b1;
        #1;
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_discard: got %b want 0", m_tvalid); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        base = cap_data.size();
        send_beat(pkt_beat(32'h9, 32'hA, 14, 1), beat_keep(1, 3), UW'(1), 1'b0, 1'b0);
        send_beat(pkt_beat(32'h9, 32'hA, 14, 2), beat_keep(2, 3), UW'(0), 1'b1, 1'b0);
        drain();
        vectors++; if (cap_data.size() != base + 2) begin miscompares++; $display("FAIL rstmid_beat_count: got %0d want 2", cap_data.size() - base); end
        if (cap_data.size() == base + 2) begin
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (cap_data[base+b] !== pkt_beat(32'h9, 32'hA, 14, b + 1) || cap_last[base+b] !== (b == 1)) begin
                    miscompares++;
                    $display("FAIL rstmid_beat%0d: got beat=%h last=%b want beat=%0d", b, cap_data[base+b][23:16], cap_last[base+b], b + 1);
                end
            end
        end
        cfg_read(ADDR_PASS_CNT, rd, rv);
        vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL rstmid_pass_cnt: got %0d want 1", rd); end
    endtask

    initial begin
        test_reset();
        test_drop_all();
        test_pass_backpressure();
        test_rule_match();
        test_priority();
        test_mode_change_mid_packet();
        test_counters();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
